mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester and the data-memory (load/store) requester of the multicycle RISC-V core.
- Sits between the control unit's fetch and write-back phases and the memory.
- Sequences each access as a request/grant/complete transaction, holds the memory-side signals stable for the whole access, and aborts accesses that exceed a latency bound.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester, memory and debug signals around the memory-port arbiter.
// Handshake: a requester raises x_req (with its address and data) and holds it
// until x_gnt; x_gnt is a one-cycle accept pulse; x_rvalid is a one-cycle
// completion pulse (err alongside it marks a timed-out access); the memory side
// sees mem_req high for the whole access and ends it by raising mem_ready.
interface mem_port_arbiter_if #(
    parameter int WORDSIZE   = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [WORDSIZE-1:0]   if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [WORDSIZE-1:0]   dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [WORDSIZE-1:0]   dm_rdata;

    logic                  err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORDSIZE-1:0]   mem_wdata;
    logic [WORDSIZE-1:0]   mem_rdata;
    logic                  mem_ready;

    // Arbiter state for observation: 0 idle, 1 fetch busy, 2 data busy.
    logic [1:0]            arb_state;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata, arb_state
    );

    // Requesters plus memory, as seen from outside the arbiter.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, arb_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters of a
// multicycle core: arbitrates in IDLE, holds the memory-side request stable for
// the whole access and aborts accesses that wait too long for mem_ready.
module mem_port_arbiter #(
    parameter int WORDSIZE      = 64,
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_PRIORITY = 1,
    parameter int TIMEOUT       = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_dm_q, last_dm_d;
    logic                  if_gnt_q, if_gnt_d;
    logic                  dm_gnt_q, dm_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic                  err_q, err_d;
    logic [WORDSIZE-1:0]   if_rdata_q, if_rdata_d;
    logic [WORDSIZE-1:0]   dm_rdata_q, dm_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [WORDSIZE-1:0]   mem_wdata_q, mem_wdata_d;

    logic busy, slot_open, accept, pick_dm, at_limit, done;
    logic mem_req_o;

    // Arbitration and completion decode. The completion (rvalid) cycle is spent
    // in IDLE without accepting, so the next access starts two cycles after the
    // memory finishes the current one.
    always_comb begin
        busy      = (state_q != S_IDLE);
        slot_open = (state_q == S_IDLE) && !(if_rvalid_q || dm_rvalid_q);
        accept    = slot_open && (bus.if_req || bus.dm_req);
        pick_dm   = bus.dm_req && (!bus.if_req || (DATA_PRIORITY != 0) || !last_dm_q);
        at_limit  = (cnt_q == CNT_LAST);
        done      = busy && (bus.mem_ready || at_limit);
    end

    // State register and all datapath flops; reset discards any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b1;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state: grant moves to the winner's busy state, completion or abort returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:               if (accept) state_d = pick_dm ? S_BUSY_DM : S_BUSY_IF;
            S_BUSY_IF, S_BUSY_DM: if (done) state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the winner's request, count wait cycles, pulse gnt/rvalid/err.
    always_comb begin
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            cnt_d     = '0;
            last_dm_d = pick_dm;
            if (pick_dm) begin
                dm_gnt_d    = 1'b1;
                mem_addr_d  = bus.dm_addr;
                mem_we_d    = bus.dm_we;
                mem_wdata_d = bus.dm_wdata;
            end else begin
                if_gnt_d    = 1'b1;
                mem_addr_d  = bus.if_addr;
                mem_we_d    = 1'b0;
            end
        end else if (done) begin
            // mem_ready wins over the wait limit, so err only marks a true abort.
            err_d = !bus.mem_ready;
            if (state_q == S_BUSY_IF) begin
                if_rvalid_d = 1'b1;
                if (bus.mem_ready) if_rdata_d = bus.mem_rdata;
            end else begin
                dm_rvalid_d = 1'b1;
                if (bus.mem_ready && !mem_we_q) dm_rdata_d = bus.mem_rdata;
            end
        end else if (busy) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Output decode: the memory request is high exactly while an access is in flight.
    always_comb begin
        mem_req_o = busy;
    end

    assign bus.mem_req   = mem_req_o;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.arb_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with data priority, one round-robin,
// both with a short wait limit, driven per access and checked against a
// transaction-level model of the arbitration and completion rules.
module tb_mem_port_arbiter;
    localparam int WS    = 64;
    localparam int AW    = 64;
    localparam int TMO   = 4;
    localparam int RQ_IF = 0;
    localparam int RQ_DM = 1;
    localparam int OW    = 7 + 3 * WS + AW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    logic          if_req_s[2];
    logic [AW-1:0] if_addr_s[2];
    logic          dm_req_s[2];
    logic          dm_we_s[2];
    logic [AW-1:0] dm_addr_s[2];
    logic [WS-1:0] dm_wdata_s[2];
    logic [WS-1:0] mem_rdata_s[2];
    logic          mem_ready_s[2];

    logic          if_gnt_s[2];
    logic          if_rvalid_s[2];
    logic [WS-1:0] if_rdata_s[2];
    logic          dm_gnt_s[2];
    logic          dm_rvalid_s[2];
    logic [WS-1:0] dm_rdata_s[2];
    logic          err_s[2];
    logic          mem_req_s[2];
    logic          mem_we_s[2];
    logic [AW-1:0] mem_addr_s[2];
    logic [WS-1:0] mem_wdata_s[2];
    logic [1:0]    state_s[2];

    // Reference model state: who was granted last, last read data per requester.
    int            last_who[2];
    logic [WS-1:0] if_rd_m[2];
    logic [WS-1:0] dm_rd_m[2];
    logic [WS-1:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORDSIZE(WS), .ADDR_WIDTH(AW)) bus [2] ();

    // Instance 0: data priority; instance 1: round-robin.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].if_req    = if_req_s[g];
        assign bus[g].if_addr   = if_addr_s[g];
        assign bus[g].dm_req    = dm_req_s[g];
        assign bus[g].dm_we     = dm_we_s[g];
        assign bus[g].dm_addr   = dm_addr_s[g];
        assign bus[g].dm_wdata  = dm_wdata_s[g];
        assign bus[g].mem_rdata = mem_rdata_s[g];
        assign bus[g].mem_ready = mem_ready_s[g];
        assign if_gnt_s[g]      = bus[g].if_gnt;
        assign if_rvalid_s[g]   = bus[g].if_rvalid;
        assign if_rdata_s[g]    = bus[g].if_rdata;
        assign dm_gnt_s[g]      = bus[g].dm_gnt;
        assign dm_rvalid_s[g]   = bus[g].dm_rvalid;
        assign dm_rdata_s[g]    = bus[g].dm_rdata;
        assign err_s[g]         = bus[g].err;
        assign mem_req_s[g]     = bus[g].mem_req;
        assign mem_we_s[g]      = bus[g].mem_we;
        assign mem_addr_s[g]    = bus[g].mem_addr;
        assign mem_wdata_s[g]   = bus[g].mem_wdata;
        assign state_s[g]       = bus[g].arb_state;

        mem_port_arbiter #(
            .WORDSIZE(WS), .ADDR_WIDTH(AW),
            .DATA_PRIORITY((g == 0) ? 1 : 0), .TIMEOUT(TMO)
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus[g])
        );
    end

    function automatic logic [WS-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic int prio_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Spec rule: single request wins; tie goes to DM with priority, else to the
    // requester that was not granted last.
    function automatic int winner(input int d);
        if (if_req_s[d] && dm_req_s[d]) begin
            if (prio_of(d) != 0) return RQ_DM;
            return (last_who[d] == RQ_DM) ? RQ_IF : RQ_DM;
        end
        return dm_req_s[d] ? RQ_DM : RQ_IF;
    endfunction

    function automatic logic gnt_of(input int d, input int w);
        return (w == RQ_DM) ? dm_gnt_s[d] : if_gnt_s[d];
    endfunction

    function automatic logic rvalid_of(input int d, input int w);
        return (w == RQ_DM) ? dm_rvalid_s[d] : if_rvalid_s[d];
    endfunction

    function automatic logic [WS-1:0] rdata_of(input int d, input int w);
        return (w == RQ_DM) ? dm_rdata_s[d] : if_rdata_s[d];
    endfunction

    function automatic logic [4:0] pulses_of(input int d);
        return {if_gnt_s[d], dm_gnt_s[d], if_rvalid_s[d], dm_rvalid_s[d], err_s[d]};
    endfunction

    function automatic logic [OW-1:0] outs_of(input int d);
        return {if_gnt_s[d], if_rvalid_s[d], if_rdata_s[d], dm_gnt_s[d], dm_rvalid_s[d],
                dm_rdata_s[d], err_s[d], mem_req_s[d], mem_we_s[d], mem_addr_s[d], mem_wdata_s[d]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            last_who[d] = RQ_DM;
            if_rd_m[d]  = '0;
            dm_rd_m[d]  = '0;
        end
        exp_q.delete();
    endtask

    // Drives one access on instance d from the acceptance edge to the cycle after
    // its completion; the memory raises mem_ready in cycle lat (cycle 1 = gnt cycle).
    task automatic run(input int d, input int lat, input logic [WS-1:0] rd, input string tag);
        int            w;
        int            e;
        bit            e_err;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [WS-1:0] e_wdata;
        logic [WS-1:0] e_rd;
        logic [WS-1:0] got;
        w       = winner(d);
        e_addr  = (w == RQ_DM) ? dm_addr_s[d] : if_addr_s[d];
        e_we    = (w == RQ_DM) ? dm_we_s[d] : 1'b0;
        e_wdata = dm_wdata_s[d];
        e       = (lat <= TMO) ? lat : TMO;
        e_err   = (lat > TMO);
        if (e_err || e_we) e_rd = (w == RQ_DM) ? dm_rd_m[d] : if_rd_m[d];
        else e_rd = rd;
        exp_q.push_back(e_rd);

        step();
        checks++;
        if (gnt_of(d, w) !== 1'b1) begin
            errors++; $display("FAIL %s gnt_winner d=%0d who=%0d got %b want 1", tag, d, w, gnt_of(d, w));
        end
        checks++;
        if (gnt_of(d, 1 - w) !== 1'b0) begin
            errors++; $display("FAIL %s gnt_loser d=%0d got %b want 0", tag, d, gnt_of(d, 1 - w));
        end
        checks++;
        if (mem_req_s[d] !== 1'b1) begin
            errors++; $display("FAIL %s mem_req_start d=%0d got %b want 1", tag, d, mem_req_s[d]);
        end
        checks++;
        if (mem_addr_s[d] !== e_addr) begin
            errors++; $display("FAIL %s mem_addr d=%0d got %h want %h", tag, d, mem_addr_s[d], e_addr);
        end
        checks++;
        if (mem_we_s[d] !== e_we) begin
            errors++; $display("FAIL %s mem_we d=%0d got %b want %b", tag, d, mem_we_s[d], e_we);
        end
        if (e_we) begin
            checks++;
            if (mem_wdata_s[d] !== e_wdata) begin
                errors++; $display("FAIL %s mem_wdata d=%0d got %h want %h", tag, d, mem_wdata_s[d], e_wdata);
            end
        end
        last_who[d] = w;
        // Winner drops its request and scrambles its inputs; the access must not notice.
        if (w == RQ_DM) begin
            dm_req_s[d] = 1'b0; dm_addr_s[d] = rand64(); dm_wdata_s[d] = rand64();
            dm_we_s[d] = 1'($urandom_range(1, 0));
        end else begin
            if_req_s[d] = 1'b0; if_addr_s[d] = rand64();
        end

        for (int c = 1; c <= e; c++) begin
            mem_ready_s[d] = (c == lat);
            mem_rdata_s[d] = (c == lat) ? rd : rand64();
            step();
            if (c < e) begin
                checks++;
                if (mem_req_s[d] !== 1'b1 || mem_addr_s[d] !== e_addr || mem_we_s[d] !== e_we) begin
                    errors++;
                    $display("FAIL %s hold c=%0d d=%0d got req=%b addr=%h we=%b want 1 %h %b",
                             tag, c, d, mem_req_s[d], mem_addr_s[d], mem_we_s[d], e_addr, e_we);
                end
                checks++;
                if (pulses_of(d) !== 5'b0) begin
                    errors++; $display("FAIL %s quiet c=%0d d=%0d got %b want 00000", tag, c, d, pulses_of(d));
                end
            end
        end
        mem_ready_s[d] = 1'b0;

        // Completion cycle
        e_rd = exp_q.pop_front();
        checks++;
        if (rvalid_of(d, w) !== 1'b1 || rvalid_of(d, 1 - w) !== 1'b0) begin
            errors++; $display("FAIL %s rvalid d=%0d who=%0d got if=%b dm=%b", tag, d, w, if_rvalid_s[d], dm_rvalid_s[d]);
        end
        checks++;
        if (err_s[d] !== e_err) begin
            errors++; $display("FAIL %s err d=%0d got %b want %b", tag, d, err_s[d], e_err);
        end
        checks++;
        if (mem_req_s[d] !== 1'b0) begin
            errors++; $display("FAIL %s mem_req_end d=%0d got %b want 0", tag, d, mem_req_s[d]);
        end
        got = rdata_of(d, w);
        checks++;
        if (got !== e_rd) begin
            errors++; $display("FAIL %s rdata d=%0d who=%0d got %h want %h", tag, d, w, got, e_rd);
        end
        if (w == RQ_DM) dm_rd_m[d] = e_rd;
        else if_rd_m[d] = e_rd;

        // The completion cycle accepts nothing, even with a request pending.
        step();
        checks++;
        if (pulses_of(d) !== 5'b0) begin
            errors++; $display("FAIL %s gap d=%0d got %b want 00000", tag, d, pulses_of(d));
        end
    endtask

    task automatic drain(input int d, input string tag);
        for (int k = 0; k < 2 && (if_req_s[d] || dm_req_s[d]); k++)
            run(d, $urandom_range(3, 1), rand64(), tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        reset_model();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs_of(d) !== '0) begin
                errors++; $display("FAIL reset_outs d=%0d got %h want 0", d, outs_of(d));
            end
            checks++;
            if (state_s[d] !== 2'd0) begin
                errors++; $display("FAIL reset_state d=%0d got %0d want 0", d, state_s[d]);
            end
        end
        rst    = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_fetch();
        if_req_s[0]  = 1'b1;
        if_addr_s[0] = 64'h100;
        run(0, 1, 64'h0050_0093, "fetch");
    endtask

    task automatic test_store();
        dm_req_s[0]   = 1'b1;
        dm_we_s[0]    = 1'b1;
        dm_addr_s[0]  = 64'h2000;
        dm_wdata_s[0] = 64'hDEAD_BEEF;
        run(0, 4, rand64(), "store");
    endtask

    task automatic test_load();
        dm_req_s[0]  = 1'b1;
        dm_we_s[0]   = 1'b0;
        dm_addr_s[0] = rand64();
        run(0, 2, rand64(), "load");
    endtask

    task automatic test_priority();
        if_req_s[0] = 1'b1; if_addr_s[0] = rand64();
        dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = rand64();
        drain(0, "prio");
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 3; k++) begin
            if (!if_req_s[1]) begin if_req_s[1] = 1'b1; if_addr_s[1] = rand64(); end
            if (!dm_req_s[1]) begin
                dm_req_s[1] = 1'b1; dm_we_s[1] = 1'($urandom_range(1, 0));
                dm_addr_s[1] = rand64(); dm_wdata_s[1] = rand64();
            end
            run(1, $urandom_range(3, 1), rand64(), "rr");
        end
        drain(1, "rr_drain");
    endtask

    task automatic test_timeout();
        dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = rand64();
        run(0, 99, rand64(), "timeout");
        if_req_s[0] = 1'b1; if_addr_s[0] = rand64();
        run(0, 2, rand64(), "after_timeout");
    endtask

    task automatic test_ready_at_limit();
        dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b0; dm_addr_s[0] = rand64();
        run(0, TMO, rand64(), "ready_at_limit");
    endtask

    task automatic test_reset_mid();
        dm_req_s[0] = 1'b1; dm_we_s[0] = 1'b1; dm_addr_s[0] = rand64(); dm_wdata_s[0] = rand64();
        step();
        checks++;
        if (dm_gnt_s[0] !== 1'b1) begin
            errors++; $display("FAIL rst_mid_gnt got %b want 1", dm_gnt_s[0]);
        end
        dm_req_s[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_model();
        checks++;
        if (outs_of(0) !== '0 || state_s[0] !== 2'd0) begin
            errors++; $display("FAIL rst_mid_outs got %h state %0d want 0", outs_of(0), state_s[0]);
        end
        mem_ready_s[0] = 1'b1;
        mem_rdata_s[0] = rand64();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (pulses_of(0) !== 5'b0 || mem_req_s[0] !== 1'b0) begin
                errors++; $display("FAIL rst_mid_quiet k=%0d got %b req %b want 0", k, pulses_of(0), mem_req_s[0]);
            end
        end
        mem_ready_s[0] = 1'b0;
        if_req_s[0] = 1'b1; if_addr_s[0] = rand64();
        run(0, 2, rand64(), "after_rst");
    endtask

    task automatic test_random();
        int         d;
        logic [1:0] pick;
        for (int i = 0; i < 30; i++) begin
            d    = $urandom_range(1, 0);
            pick = 2'($urandom_range(3, 1));
            if_req_s[d] = pick[0]; if_addr_s[d] = rand64();
            dm_req_s[d] = pick[1]; dm_we_s[d] = 1'($urandom_range(1, 0));
            dm_addr_s[d] = rand64(); dm_wdata_s[d] = rand64();
            for (int k = 0; k < 2 && (if_req_s[d] || dm_req_s[d]); k++)
                run(d, $urandom_range(6, 1), rand64(), "rand");
        end
    endtask

    // Scoreboard-side invariants checked every cycle.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ($countones({if_gnt_s[d], dm_gnt_s[d], if_rvalid_s[d], dm_rvalid_s[d]}) > 1) begin
                    errors++; $display("FAIL onehot d=%0d got %b%b%b%b want at most one", d,
                                       if_gnt_s[d], dm_gnt_s[d], if_rvalid_s[d], dm_rvalid_s[d]);
                end
                checks++;
                if (err_s[d] && !(if_rvalid_s[d] || dm_rvalid_s[d])) begin
                    errors++; $display("FAIL err_alone d=%0d got err=1 without rvalid", d);
                end
                checks++;
                if (mem_req_s[d] && state_s[d] == 2'd0) begin
                    errors++; $display("FAIL req_in_idle d=%0d got mem_req=1 want 0", d);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            if_req_s[d] = 1'b0; if_addr_s[d] = '0; dm_req_s[d] = 1'b0; dm_we_s[d] = 1'b0;
            dm_addr_s[d] = '0; dm_wdata_s[d] = '0; mem_rdata_s[d] = '0; mem_ready_s[d] = 1'b0;
        end
        test_reset();
        test_round_robin();
        test_fetch();
        test_store();
        test_load();
        test_priority();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
